muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit inside the execute stage, directly upstream of the memory stage.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants (MULW/DIVW/DIVUW/REMW/REMUW).
- Raises `stall` while busy, so execute holds its outputs toward memory until `done`, mirroring how memory raises `stopm` on the dbus.

---
 rtl/muldiv_unit_if.sv | 32 +++
 rtl/muldiv_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Execute-stage <-> multiply/divide unit handshake bundle.
//            The execute stage (master) presents the op and operands and
//            watches stall/done. The unit (slave) returns the result.
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            flushall;
  logic            valid;
  logic [2:0]      funct3;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            stall;

  modport master (
    output flushall, valid, funct3, word, a, b,
    input  result, done, stall
  );

  modport slave (
    input  flushall, valid, funct3, word, a, b,
    output result, done, stall
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV64M multiply/divide unit. Radix-2 shift-add
//            multiply and restoring divide, one bit per cycle. Divide by
//            zero and signed overflow finish without iterating.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave io_md
);

  localparam logic [6:0] c_cnt_dword = 7'd64;
  localparam logic [6:0] c_cnt_word  = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operation and iteration state
  logic [2:0]        r_funct3;
  logic              r_word;
  logic [6:0]        r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_neg;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;

  // Accept-side decode
  logic              w_is_div;
  logic              w_div_signed;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_sx;
  logic [XLEN-1:0]   w_b_sx;
  logic [XLEN-1:0]   w_a_zx;
  logic [XLEN-1:0]   w_b_zx;
  logic [XLEN-1:0]   w_opa;
  logic [XLEN-1:0]   w_opb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN-1:0]   w_dvd_res;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  // Iteration and result formation
  logic [XLEN:0]     w_acc;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [2*XLEN-1:0] w_pfix;
  logic [XLEN:0]     w_shift;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_q_raw;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_mul_lo32;
  logic [XLEN-1:0]   w_final;
  logic              w_done;

  // Decode the incoming op: operand extension, magnitudes, special cases
  always_comb begin
    w_is_div     = io_md.funct3[2];
    w_div_signed = w_is_div & ~io_md.funct3[0];
    w_a_sx       = {{(XLEN-32){io_md.a[31]}}, io_md.a[31:0]};
    w_b_sx       = {{(XLEN-32){io_md.b[31]}}, io_md.b[31:0]};
    w_a_zx       = {{(XLEN-32){1'b0}}, io_md.a[31:0]};
    w_b_zx       = {{(XLEN-32){1'b0}}, io_md.b[31:0]};
    // mulw only needs the low product bits, so zero-extension is enough
    w_opa        = io_md.word ? (w_div_signed ? w_a_sx : w_a_zx) : io_md.a;
    w_opb        = io_md.word ? (w_div_signed ? w_b_sx : w_b_zx) : io_md.b;
    w_a_signed   = w_is_div ? w_div_signed
                            : (io_md.funct3 == 3'b001 || io_md.funct3 == 3'b010);
    w_b_signed   = w_is_div ? w_div_signed : (io_md.funct3 == 3'b001);
    w_a_neg      = w_a_signed & w_opa[XLEN-1];
    w_b_neg      = w_b_signed & w_opb[XLEN-1];
    w_abs_a      = w_a_neg ? -w_opa : w_opa;
    w_abs_b      = w_b_neg ? -w_opb : w_opb;
    // Dividend as it must appear in a result (W results sign-extend bit 31)
    w_dvd_res    = io_md.word ? w_a_sx : io_md.a;
    w_div0       = w_is_div & (io_md.word ? (io_md.b[31:0] == 32'd0)
                                          : (io_md.b == '0));
    w_ovf        = w_div_signed &
                   (io_md.word ? (io_md.a[31:0] == 32'h8000_0000 &&
                                  io_md.b[31:0] == 32'hFFFF_FFFF)
                               : (io_md.a == {1'b1, {(XLEN-1){1'b0}}} &&
                                  io_md.b == '1));
    w_special    = w_div0 | w_ovf;
    if (w_div0) begin
      w_special_res = io_md.funct3[1] ? w_dvd_res : '1;
    end else begin
      w_special_res = io_md.funct3[1] ? '0 : w_dvd_res;
    end
  end

  // One multiply / divide step plus the result that step would finish with
  always_comb begin
    w_acc      = r_prod[0] ? ({1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_mcand})
                           : {1'b0, r_prod[2*XLEN-1:XLEN]};
    w_prod_nxt = {w_acc, r_prod[XLEN-1:1]};
    w_pfix     = r_neg ? -w_prod_nxt : w_prod_nxt;
    // After 32 steps the 32x32 product sits at [95:32]; its low word is [63:32]
    w_mul_lo32 = {{(XLEN-32){w_prod_nxt[63]}}, w_prod_nxt[63:32]};

    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_qbit     = (w_shift >= {1'b0, r_dvsr});
    w_rem_nxt  = w_qbit ? XLEN'(w_shift - {1'b0, r_dvsr}) : w_shift[XLEN-1:0];
    w_quo_nxt  = {r_quo[XLEN-2:0], w_qbit};
    w_q_raw    = r_word ? {{(XLEN-32){1'b0}}, w_quo_nxt[31:0]} : w_quo_nxt;
    w_q        = r_neg ? -w_q_raw : w_q_raw;
    w_r        = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    w_div_res  = r_funct3[1] ? w_r : w_q;

    if (r_funct3[2]) begin
      w_final = r_word ? {{(XLEN-32){w_div_res[31]}}, w_div_res[31:0]} : w_div_res;
    end else if (r_funct3[1:0] == 2'b00) begin
      w_final = r_word ? w_mul_lo32 : w_pfix[XLEN-1:0];
    end else begin
      w_final = w_pfix[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_md.valid) begin
          w_state_nxt = w_special ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!io_md.valid) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 7'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (io_md.flushall) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Datapath: latch operands on accept, iterate while busy, capture result
  always_ff @(posedge clk) begin
    if (reset || io_md.flushall) begin
      r_funct3 <= '0;
      r_word   <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_md.valid) begin
            r_funct3 <= io_md.funct3;
            r_word   <= io_md.word;
            r_cnt    <= io_md.word ? c_cnt_word : c_cnt_dword;
            r_mcand  <= w_abs_a;
            r_prod   <= {{XLEN{1'b0}}, w_abs_b};
            r_dvsr   <= w_abs_b;
            // W dividends are pre-aligned so 32 steps consume all their bits
            r_quo    <= io_md.word ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
            r_rem    <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        S_BUSY: begin
          if (io_md.valid) begin
            r_cnt <= r_cnt - 7'd1;
            if (r_funct3[2]) begin
              r_quo <= w_quo_nxt;
              r_rem <= w_rem_nxt;
            end else begin
              r_prod <= w_prod_nxt;
            end
            if (r_cnt == 7'd1) begin
              r_result <= w_final;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_done       = (r_state == S_DONE);
  assign io_md.done   = w_done;
  assign io_md.result = r_result;
  assign io_md.stall  = io_md.valid & ~w_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(64)) bus ();

  muldiv_unit #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .io_md (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_double = 0;
  int last_done_cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Track done pulses for abort and back-to-back checks
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done        = n_done + 1;
      last_done_cyc = cyc;
      if (prev_done === 1'b1) n_double = n_double + 1;
    end
    prev_done = bus.done;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge with the op driven (cycle 0).
  // Returns at the falling edge of the done cycle, or lat=-1 on timeout.
  task automatic wait_done(input int max_cyc, output int lat, output bit stall_ok);
    lat      = -1;
    stall_ok = 1'b1;
    for (int c = 0; c <= max_cyc; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] fn, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    bit sok;
    bus.valid  = 1'b1;
    bus.funct3 = fn;
    bus.word   = w;
    bus.a      = a;
    bus.b      = b;
    wait_done(200, lat, sok);
    check_val({tag, "_lat"},   64'(lat), 64'(exp_lat));
    check_val({tag, "_res"},   bus.result, exp);
    check_val({tag, "_stall"}, {63'd0, sok}, 64'd1);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  initial begin
    int lat;
    bit sok;
    int n0;
    int t0;

    reset        = 1'b1;
    bus.flushall = 1'b0;
    bus.valid    = 1'b0;
    bus.funct3   = 3'b000;
    bus.word     = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_done",   {63'd0, bus.done},  64'd0);
    check_val("rst_stall",  {63'd0, bus.stall}, 64'd0);
    check_val("rst_result", bus.result,         64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Multiplies
    do_op("mul",    3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    do_op("mulh",   3'b001, 1'b0, '1, '1, 64'h0, 65);
    do_op("mulhu",  3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("mulhsu", 3'b010, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("mulw",   3'b000, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Divides
    do_op("div",    3'b100, 1'b0, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem",    3'b110, 1'b0, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("divu",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    do_op("divuw",  3'b101, 1'b1, 64'h1_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33);
    do_op("remw",   3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Special cases
    do_op("div0",   3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem0",   3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_op("remwovf",3'b110, 1'b1, 64'h8000_0000, '1, 64'd0, 1);
    do_op("remuw0", 3'b111, 1'b1, 64'h8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);

    // Flush in cycle 10 of a divide, then a new multiply in cycle 11
    n0         = n_done;
    bus.valid  = 1'b1;
    bus.funct3 = 3'b100;
    bus.word   = 1'b0;
    bus.a      = 64'd100;
    bus.b      = 64'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flushall = 1'b1;
    @(posedge clk);
    #1;
    bus.flushall = 1'b0;
    bus.funct3   = 3'b000;
    bus.a        = 64'd6;
    bus.b        = 64'd9;
    check_val("flush_no_done", 64'(n_done - n0), 64'd0);
    wait_done(200, lat, sok);
    check_val("flush_mul_lat", 64'(lat), 64'd65);
    check_val("flush_mul_res", bus.result, 64'd54);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;

    // valid dropping while busy aborts silently
    n0         = n_done;
    bus.valid  = 1'b1;
    bus.funct3 = 3'b000;
    bus.a      = 64'd3;
    bus.b      = 64'd4;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check_val("vdrop_no_done", 64'(n_done - n0), 64'd0);
    do_op("after_vdrop", 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);

    // Reset mid-operation discards it and clears the result
    n0         = n_done;
    bus.valid  = 1'b1;
    bus.funct3 = 3'b101;
    bus.a      = 64'd1000;
    bus.b      = 64'd3;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_no_done", 64'(n_done - n0), 64'd0);
    check_val("rst_mid_result",  bus.result, 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back: second accept lands the cycle after the first done
    t0 = cyc;
    do_op("b2b_1", 3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    do_op("b2b_2", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 65);
    check_val("b2b_abs_cycle", 64'(last_done_cyc - t0), 64'd131);
    check_val("no_double_done", 64'(n_double), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
